// File: rtl/button_conditioner.sv
// -----------------------------------------------------------------------------
// button_conditioner
//
// Debounces N_BTN raw button inputs and turns each debounced press into a
// single-cycle press pulse. If a button stays held with auto-repeat enabled,
// the channel also produces repeat pulses: the first one REPEAT_DELAY cycles
// after the press pulse, then one every REPEAT_RATE cycles.
// Every channel is a fully independent copy of the same logic.
//
// Parameters
//   N_BTN        number of button channels (bit 0 = volume up, bit 1 = down)
//   DEB_DEPTH    debounce shift-register length in clk samples (2..16)
//   REPEAT_DELAY cycles from the press pulse to the first repeat pulse (>= 2)
//   REPEAT_RATE  cycles between successive repeat pulses (>= 1)
//
// Ports
//   clk        single clock for all logic (normally the divided clock)
//   rst        synchronous, active-high reset
//   btn_in     raw, possibly bouncing, button levels
//   repeat_en  per-channel auto-repeat enable, sampled every clk
//   btn_level  debounced level, registered
//   btn_pulse  single-cycle press / repeat pulses, registered
//   btn_held   high while the channel is in the REPEAT state, registered
// -----------------------------------------------------------------------------
module button_conditioner #(
    parameter int N_BTN        = 2,
    parameter int DEB_DEPTH    = 4,
    parameter int REPEAT_DELAY = 16,
    parameter int REPEAT_RATE  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_in,
    input  logic [N_BTN-1:0] repeat_en,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_pulse,
    output logic [N_BTN-1:0] btn_held
);

    localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;

    // Terminal counts: the counter starts at 0 on the edge that emits the
    // previous pulse, so the next pulse is due when it reaches interval-1.
    localparam logic [CNT_W-1:0] DELAY_TC = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RATE_TC  = CNT_W'(REPEAT_RATE - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_HOLD   = 2'd1,
        S_REPEAT = 2'd2
    } state_e;

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch

        logic [DEB_DEPTH-1:0] sr_q,    sr_d;
        logic                 level_q, level_d;
        logic                 pulse_q, pulse_d;
        logic                 held_q,  held_d;
        logic                 en_q;
        logic [CNT_W-1:0]     cnt_q,   cnt_d;
        state_e               state_q, state_d;

        // ---------------------------------------------------------------
        // Debounce: shift register with hysteresis on the output level.
        // ---------------------------------------------------------------
        always_comb begin
            sr_d    = {sr_q[DEB_DEPTH-2:0], btn_in[i]};
            level_d = level_q;
            if (&sr_q) begin
                level_d = 1'b1;
            end else if (~|sr_q) begin
                level_d = 1'b0;
            end
        end

        // ---------------------------------------------------------------
        // Press / repeat FSM, next-state and registered outputs.
        // ---------------------------------------------------------------
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            pulse_d = 1'b0;

            unique case (state_q)
                S_IDLE: begin
                    cnt_d = '0;
                    if (level_q) begin
                        state_d = S_HOLD;
                        pulse_d = 1'b1;
                    end
                end

                S_HOLD: begin
                    if (!level_q) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end else if (!repeat_en[i] || !en_q) begin
                        // Counting only starts once the enable has been seen
                        // high on the previous edge too, so a re-enable
                        // restarts a full REPEAT_DELAY interval just like a
                        // fresh press does.
                        cnt_d = '0;
                    end else if (cnt_q == DELAY_TC) begin
                        state_d = S_REPEAT;
                        cnt_d   = '0;
                        pulse_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end

                S_REPEAT: begin
                    if (!level_q) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end else if (!repeat_en[i]) begin
                        state_d = S_HOLD;
                        cnt_d   = '0;
                    end else if (cnt_q == RATE_TC) begin
                        cnt_d   = '0;
                        pulse_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end

                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            endcase

            held_d = (state_d == S_REPEAT);
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                sr_q    <= '0;
                level_q <= 1'b0;
                pulse_q <= 1'b0;
                held_q  <= 1'b0;
                en_q    <= 1'b0;
                cnt_q   <= '0;
                state_q <= S_IDLE;
            end else begin
                sr_q    <= sr_d;
                level_q <= level_d;
                pulse_q <= pulse_d;
                held_q  <= held_d;
                en_q    <= repeat_en[i];
                cnt_q   <= cnt_d;
                state_q <= state_d;
            end
        end

        assign btn_level[i] = level_q;
        assign btn_pulse[i] = pulse_q;
        assign btn_held[i]  = held_q;

    end : g_ch

endmodule

// File: tb/tb_button_conditioner.sv
// -----------------------------------------------------------------------------
// tb_button_conditioner
//
// Directed bench for button_conditioner with default parameters. Edge numbers
// in each scenario count from 1 = first clk edge after the reset phase; an
// input value given for edge e is the value sampled at edge e, and outputs
// are sampled 1 time unit after that edge.
// -----------------------------------------------------------------------------
module tb_button_conditioner;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] btn_in;
    logic [1:0] repeat_en;
    logic [1:0] btn_level;
    logic [1:0] btn_pulse;
    logic [1:0] btn_held;

    int vectors     = 0;
    int miscompares = 0;
    int pulse_cnt0  = 0;

    typedef struct packed {
        logic [1:0] level;
        logic [1:0] pulse;
        logic [1:0] held;
    } exp_t;

    exp_t sb[$];

    button_conditioner #(
        .N_BTN        (2),
        .DEB_DEPTH    (4),
        .REPEAT_DELAY (16),
        .REPEAT_RATE  (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_in    (btn_in),
        .repeat_en (repeat_en),
        .btn_level (btn_level),
        .btn_pulse (btn_pulse),
        .btn_held  (btn_held)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check2(input string tag, input int e,
                          input logic [1:0] obs, input logic [1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s edge %0d: observed %b expected %b", tag, e, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs == exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive one edge worth of inputs, queue the expected outputs, then pop
    // and compare once the DUT has clocked.
    task automatic step(input string tag, input int e, input logic r,
                        input logic [1:0] b, input logic [1:0] en,
                        input logic [1:0] el, input logic [1:0] ep,
                        input logic [1:0] eh);
        exp_t x;
        exp_t got;
        rst       = r;
        btn_in    = b;
        repeat_en = en;
        x.level   = el;
        x.pulse   = ep;
        x.held    = eh;
        sb.push_back(x);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check_int({tag, ".sb_empty"}, 0, 1);
        end else begin
            got = sb.pop_front();
            check2({tag, ".level"}, e, btn_level, got.level);
            check2({tag, ".pulse"}, e, btn_pulse, got.pulse);
            check2({tag, ".held"},  e, btn_held,  got.held);
        end
        if (btn_pulse[0] === 1'b1) pulse_cnt0++;
    endtask

    task automatic do_reset(input string tag);
        step(tag, 0, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        step(tag, 0, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        pulse_cnt0 = 0;
    endtask

    function automatic logic [1:0] b0(input bit c);
        return {1'b0, c};
    endfunction

    initial begin
        logic [6:0] pat;
        bit         l, p, h, b, en;

        rst       = 1'b1;
        btn_in    = 2'b00;
        repeat_en = 2'b00;

        // Reset state
        do_reset("reset");

        // Clean press, no repeat: level 5..14, single pulse at 6
        for (int e = 1; e <= 24; e++) begin
            l = (e >= 5 && e <= 14);
            p = (e == 6);
            step("press", e, 1'b0, b0(e <= 10), 2'b00, b0(l), b0(p), 2'b00);
        end
        check_int("press.count", pulse_cnt0, 1);

        // Bounce on channel 1: 1,0,1,1,0,1,0 then 0s -> nothing
        do_reset("reset_b");
        pat = 7'b0101101;
        for (int e = 1; e <= 20; e++) begin
            b = (e <= 7) ? pat[e-1] : 1'b0;
            step("bounce", e, 1'b0, {b, 1'b0}, 2'b11, 2'b00, 2'b00, 2'b00);
        end

        // Auto-repeat. Release is placed so that the repeat pulse due at
        // edge 42 lands on the cycle the level has dropped and is suppressed.
        do_reset("reset_c");
        for (int e = 1; e <= 46; e++) begin
            l = (e >= 5 && e <= 40);
            p = (e == 6 || e == 22 || e == 26 || e == 30 || e == 34 || e == 38);
            h = (e >= 22 && e <= 41);
            step("repeat", e, 1'b0, b0(e <= 36), 2'b01, b0(l), b0(p), b0(h));
        end
        check_int("repeat.count", pulse_cnt0, 6);

        // Simultaneous press on both channels
        do_reset("reset_d");
        for (int e = 1; e <= 22; e++) begin
            l = (e >= 5 && e <= 16);
            p = (e == 6);
            step("simul", e, 1'b0, (e <= 12) ? 2'b11 : 2'b00, 2'b00,
                 {l, l}, {p, p}, 2'b00);
        end

        // Enable dropped for edges 24..29 while held
        do_reset("reset_e");
        for (int e = 1; e <= 58; e++) begin
            en = !(e >= 24 && e <= 29);
            l  = (e >= 5 && e <= 52);
            p  = (e == 6 || e == 22 || e == 46 || e == 50);
            h  = (e >= 22 && e <= 23) || (e >= 46 && e <= 53);
            step("endrop", e, 1'b0, b0(e <= 48), b0(en), b0(l), b0(p), b0(h));
        end
        check_int("endrop.count", pulse_cnt0, 4);

        // Reset pulse at edge 28 while held in REPEAT
        do_reset("reset_f");
        for (int e = 1; e <= 54; e++) begin
            l = (e >= 5 && e <= 27) || (e >= 33 && e <= 48);
            p = (e == 6 || e == 22 || e == 26 || e == 34);
            h = (e >= 22 && e <= 27);
            step("midrst", e, (e == 28), b0(e <= 44), 2'b01, b0(l), b0(p), b0(h));
        end

        // Three-sample dropout while held: level and pulses unaffected
        do_reset("reset_g");
        for (int e = 1; e <= 40; e++) begin
            b = (e <= 30) && !(e >= 12 && e <= 14);
            l = (e >= 5 && e <= 34);
            p = (e == 6);
            step("glitch", e, 1'b0, b0(b), 2'b00, b0(l), b0(p), 2'b00);
        end
        check_int("glitch.count", pulse_cnt0, 1);

        check_int("sb.drained", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
